// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared defaults for the fetch PC generator and its return-address stack
`ifndef INITIAL_PC
`define INITIAL_PC 32'h0000_1000
`endif
`ifndef EXCEPTION_PC
`define EXCEPTION_PC 32'h0000_0100
`endif

package fetch_pc_gen_pkg;
   localparam int DEFAULT_XLEN       = 32;
   localparam int DEFAULT_INST_BYTES = 4;
   localparam int DEFAULT_RAS_DEPTH  = 4;
endpackage

// File: rtl/fetch_pc_gen_ras.sv
// rtl/fetch_pc_gen_ras.sv - circular return-address stack with saturating count and sticky overflow
module ras_stack
   import fetch_pc_gen_pkg::*;
#(
   parameter int DEPTH = DEFAULT_RAS_DEPTH,
   parameter int WIDTH = DEFAULT_XLEN
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;
   logic [CW-1:0]    cnt;
   logic             ovf;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (cnt != '0) && !flush;
   assign do_push = push && !flush;

   // A pop+push pair replaces the top in place; a lone push when full lands on the oldest slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
      end else if (do_push && do_pop) begin
         ptr <= ptr;
      end else if (do_push) begin
         ptr <= ptr + PW'(1);
         if (cnt == CW'(DEPTH))
            ovf <= 1'b1;
         else
            cnt <= cnt + CW'(1);
      end else if (do_pop) begin
         ptr <= ptr - PW'(1);
         cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) begin
         if (do_pop)
            mem[ptr] <= wdata;
         else
            mem[ptr + PW'(1)] <= wdata;
      end
   end

   assign top      = mem[ptr];
   assign count    = cnt;
   assign overflow = ovf;
endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC register, next-PC redirect mux and RAS call/return tracking
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter int              XLEN       = DEFAULT_XLEN,
   parameter int              INST_BYTES = DEFAULT_INST_BYTES,
   parameter logic [XLEN-1:0] RESET_PC   = `INITIAL_PC,
   parameter logic [XLEN-1:0] EXC_PC     = `EXCEPTION_PC,
   parameter int              RAS_DEPTH  = DEFAULT_RAS_DEPTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        pc_write,
   input  logic                        exc_valid,
   input  logic                        jump_valid,
   input  logic [XLEN-1:0]             jump_target,
   input  logic                        jump_is_call,
   input  logic                        jump_is_ret,
   input  logic                        branch_valid,
   input  logic [XLEN-1:0]             branch_target,
   output logic [XLEN-1:0]             out_pc,
   output logic [XLEN-1:0]             next_pc,
   output logic [$clog2(RAS_DEPTH):0]  ras_count,
   output logic                        ras_overflow
);
   localparam logic [1:0] SEL_SEQ = 2'd0;
   localparam logic [1:0] SEL_BR  = 2'd1;
   localparam logic [1:0] SEL_JMP = 2'd2;
   localparam logic [1:0] SEL_EXC = 2'd3;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] ras_top;
   logic [XLEN-1:0] jmp_pc;
   logic [1:0]      sel;
   logic            ras_op;

   assign out_pc = reset ? RESET_PC : pc_q;
   assign seq_pc = out_pc + XLEN'(INST_BYTES);
   assign ras_op = pc_write && jump_valid && !exc_valid;

   // An empty stack cannot predict a return, so the decoded target is used instead.
   assign jmp_pc = (jump_is_ret && (ras_count != '0)) ? ras_top : jump_target;

   always_comb begin
      sel = SEL_SEQ;
      if (exc_valid)
         sel = SEL_EXC;
      else if (jump_valid)
         sel = SEL_JMP;
      else if (branch_valid)
         sel = SEL_BR;
   end

   always_comb begin
      next_pc = seq_pc;
      case (sel)
         SEL_EXC: next_pc = EXC_PC & ALIGN_MASK;
         SEL_JMP: next_pc = jmp_pc & ALIGN_MASK;
         SEL_BR:  next_pc = branch_target & ALIGN_MASK;
         default: next_pc = seq_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= RESET_PC;
      else if (pc_write || exc_valid)
         pc_q <= next_pc;
   end

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (XLEN)
   ) u_ras (
      .clk      (clk),
      .reset    (reset),
      .push     (ras_op && jump_is_call),
      .pop      (ras_op && jump_is_ret),
      .flush    (exc_valid),
      .wdata    (seq_pc),
      .top      (ras_top),
      .count    (ras_count),
      .overflow (ras_overflow)
   );
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - directed and randomized bench for fetch_pc_gen against a queue-based model
module tb_fetch_pc_gen;
   localparam logic [31:0] RST_PC  = 32'h0000_1000;
   localparam logic [31:0] EXC_VEC = 32'h0000_0100;
   localparam int          DEPTH   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_write, exc_valid, jump_valid, jump_is_call, jump_is_ret, branch_valid;
   logic [31:0] jump_target, branch_target;
   logic [31:0] out_pc, next_pc;
   logic [2:0]  ras_count;
   logic        ras_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   logic        m_ovf;

   always #5 clk = ~clk;

   fetch_pc_gen #(
      .XLEN(32), .INST_BYTES(4), .RESET_PC(RST_PC), .EXC_PC(EXC_VEC), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .pc_write(pc_write), .exc_valid(exc_valid),
      .jump_valid(jump_valid), .jump_target(jump_target), .jump_is_call(jump_is_call),
      .jump_is_ret(jump_is_ret), .branch_valid(branch_valid), .branch_target(branch_target),
      .out_pc(out_pc), .next_pc(next_pc), .ras_count(ras_count), .ras_overflow(ras_overflow)
   );

   function automatic logic [31:0] m_next();
      logic [31:0] t;
      if (exc_valid) t = EXC_VEC;
      else if (jump_valid) t = (jump_is_ret && m_ras.size() > 0) ? m_ras[m_ras.size()-1] : jump_target;
      else if (branch_valid) t = branch_target;
      else return m_pc + 32'd4;
      return {t[31:2], 2'b00};
   endfunction

   function automatic void m_update();
      logic [31:0] nxt;
      logic [31:0] ret_addr;
      nxt = m_next();
      ret_addr = m_pc + 32'd4;
      if (exc_valid) begin
         m_ras.delete();
      end else if (pc_write && jump_valid) begin
         if (jump_is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
         if (jump_is_call) begin
            m_ras.push_back(ret_addr);
            if (m_ras.size() > DEPTH) begin
               void'(m_ras.pop_front());
               m_ovf = 1'b1;
            end
         end
      end
      if (pc_write || exc_valid) m_pc = nxt;
   endfunction

   task automatic drive(input logic pw, input logic ex, input logic jv, input logic [31:0] jt,
                        input logic call, input logic ret, input logic bv, input logic [31:0] bt);
      pc_write = pw; exc_valid = ex; jump_valid = jv; jump_target = jt;
      jump_is_call = call; jump_is_ret = ret; branch_valid = bv; branch_target = bt;
   endtask

   task automatic step();
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic reset_dut();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_pc !== RST_PC) begin
         n_fail++; $display("FAIL reset_out_pc_during got %h exp %h", out_pc, RST_PC);
      end
      reset = 1'b0;
      m_pc = RST_PC; m_ras.delete(); m_ovf = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      n_checks++;
      if (out_pc !== 32'h1000) begin n_fail++; $display("FAIL reset_pc got %h exp %h", out_pc, 32'h1000); end
      n_checks++;
      if (ras_count !== 3'd0 || ras_overflow !== 1'b0) begin
         n_fail++; $display("FAIL reset_ras got cnt=%0d ovf=%b exp cnt=0 ovf=0", ras_count, ras_overflow);
      end
      step();
      n_checks++;
      if (out_pc !== 32'h1004) begin n_fail++; $display("FAIL seq_1 got %h exp %h", out_pc, 32'h1004); end
      step();
      n_checks++;
      if (out_pc !== 32'h1008) begin n_fail++; $display("FAIL seq_2 got %h exp %h", out_pc, 32'h1008); end
   endtask

   task automatic test_exception();
      drive(1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 1'b0, 1'b1, 32'h4000);
      #1;
      n_checks++;
      if (next_pc !== EXC_VEC) begin n_fail++; $display("FAIL exc_next_pc got %h exp %h", next_pc, EXC_VEC); end
      step();
      n_checks++;
      if (out_pc !== EXC_VEC || ras_count !== 3'd0) begin
         n_fail++; $display("FAIL exc_redirect got pc=%h cnt=%0d exp pc=%h cnt=0", out_pc, ras_count, EXC_VEC);
      end
   endtask

   task automatic test_call_ret();
      reset_dut();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2000);
      step();
      drive(1'b1, 1'b0, 1'b1, 32'h3000, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      n_checks++;
      if (out_pc !== 32'h3000 || ras_count !== 3'd1) begin
         n_fail++; $display("FAIL call got pc=%h cnt=%0d exp pc=3000 cnt=1", out_pc, ras_count);
      end
      drive(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 32'h0);
      #1;
      n_checks++;
      if (next_pc !== 32'h2004) begin n_fail++; $display("FAIL ret_next_pc got %h exp %h", next_pc, 32'h2004); end
      step();
      n_checks++;
      if (out_pc !== 32'h2004 || ras_count !== 3'd0) begin
         n_fail++; $display("FAIL ret got pc=%h cnt=%0d exp pc=2004 cnt=0", out_pc, ras_count);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] ret_addr [5];
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         ret_addr[i] = (i == 0) ? 32'h1004 : 32'h4000 + 32'(i - 1) * 32'h100 + 32'd4;
         drive(1'b1, 1'b0, 1'b1, 32'h4000 + 32'(i) * 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
         step();
      end
      n_checks++;
      if (ras_count !== 3'd4 || ras_overflow !== 1'b1) begin
         n_fail++; $display("FAIL overflow got cnt=%0d ovf=%b exp cnt=4 ovf=1", ras_count, ras_overflow);
      end
      for (int i = 4; i >= 1; i--) begin
         drive(1'b1, 1'b0, 1'b1, 32'hBEEF0, 1'b0, 1'b1, 1'b0, 32'h0);
         step();
         n_checks++;
         if (out_pc !== ret_addr[i]) begin
            n_fail++; $display("FAIL lifo_ret_%0d got %h exp %h", i, out_pc, ret_addr[i]);
         end
      end
      drive(1'b1, 1'b0, 1'b1, 32'h5000, 1'b0, 1'b1, 1'b0, 32'h0);
      step();
      n_checks++;
      if (out_pc !== 32'h5000 || ras_count !== 3'd0 || ras_overflow !== 1'b1) begin
         n_fail++; $display("FAIL empty_ret got pc=%h cnt=%0d ovf=%b exp pc=5000 cnt=0 ovf=1",
                            out_pc, ras_count, ras_overflow);
      end
   endtask

   task automatic test_stall();
      reset_dut();
      drive(1'b0, 1'b0, 1'b1, 32'h6000, 1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      n_checks++;
      if (next_pc !== 32'h6000) begin n_fail++; $display("FAIL stall_next_pc got %h exp %h", next_pc, 32'h6000); end
      step();
      n_checks++;
      if (out_pc !== 32'h1000 || ras_count !== 3'd0) begin
         n_fail++; $display("FAIL stall_hold got pc=%h cnt=%0d exp pc=1000 cnt=0", out_pc, ras_count);
      end
   endtask

   task automatic test_wrap();
      reset_dut();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      n_checks++;
      if (out_pc !== 32'h0) begin n_fail++; $display("FAIL wrap got %h exp %h", out_pc, 32'h0); end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1003);
      step();
      n_checks++;
      if (out_pc !== 32'h1000) begin n_fail++; $display("FAIL align got %h exp %h", out_pc, 32'h1000); end
   endtask

   task automatic test_random();
      logic [31:0] exp_next;
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
               $urandom, $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom);
         #1;
         exp_next = m_next();
         n_checks++;
         if (next_pc !== exp_next) begin
            n_fail++; $display("FAIL rand_next_pc[%0d] got %h exp %h", i, next_pc, exp_next);
         end
         step();
         n_checks++;
         if (out_pc !== m_pc || ras_count !== 3'(m_ras.size()) || ras_overflow !== m_ovf) begin
            n_fail++; $display("FAIL rand_state[%0d] got pc=%h cnt=%0d ovf=%b exp pc=%h cnt=%0d ovf=%b",
                               i, out_pc, ras_count, ras_overflow, m_pc, m_ras.size(), m_ovf);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      test_reset();
      test_exception();
      test_call_ret();
      test_overflow();
      test_stall();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
